// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: parameter width derivation,
// explicit pointer wrap for any depth, and the push/pop operation encoding.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap is explicit so non-power-of-two depths work.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and status-flag controller driving the write and read
// sides of simple_dual_port_ram; rd_valid_o lines up with the RAM's registered read.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = addr_width(DEPTH),
    parameter int CNT_WIDTH  = cnt_width(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic                  we_o,
    output logic                  re_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CNT_WIDTH-1:0]  count_q, count_nxt;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  rd_valid_q, ovf_q, unf_q;
    logic                  push_ok, pop_ok;
    fifo_op_e              op;

    // Requests are qualified by reset so nothing reaches the RAM in a reset cycle.
    always_comb begin
        pop_ok  = n_rst_i & pop_i & ~empty_q;
        push_ok = n_rst_i & push_i & (~full_q | pop_ok);
        op      = fifo_op_e'({push_ok, pop_ok});
    end

    always_comb begin
        count_nxt = count_q;
        wptr_nxt  = wptr_q;
        rptr_nxt  = rptr_q;
        case (op)
            OP_PUSH: count_nxt = count_q + CNT_WIDTH'(1);
            OP_POP:  count_nxt = count_q - CNT_WIDTH'(1);
            default: count_nxt = count_q;
        endcase
        if (push_ok) begin
            wptr_nxt = ADDR_WIDTH'(ptr_next(32'(wptr_q), DEPTH));
        end
        if (pop_ok) begin
            rptr_nxt = ADDR_WIDTH'(ptr_next(32'(rptr_q), DEPTH));
        end
    end

    // Flags come from the next count so they change together with count_o.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= (AF_THRESH == 0);
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_nxt;
            rptr_q     <= rptr_nxt;
            count_q    <= count_nxt;
            full_q     <= (32'(count_nxt) == DEPTH);
            empty_q    <= (count_nxt == '0);
            af_q       <= (32'(count_nxt) >= AF_THRESH);
            ae_q       <= (32'(count_nxt) <= AE_THRESH);
            rd_valid_q <= pop_ok;
            ovf_q      <= ovf_q | (push_i & full_q & ~pop_ok);
            unf_q      <= unf_q | (pop_i & empty_q);
        end
    end

    always_comb begin
        we_o           = push_ok;
        re_o           = pop_ok;
        waddr_o        = wptr_q;
        raddr_o        = rptr_q;
        rd_valid_o     = rd_valid_q;
        full_o         = full_q;
        empty_o        = empty_q;
        almost_full_o  = af_q;
        almost_empty_o = ae_q;
        count_o        = count_q;
        overflow_o     = ovf_q;
        underflow_o    = unf_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with DEPTH=8: a queue-based reference
// model plus a behavioural read-before-write RAM fed by the controller's outputs.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [7:0]    wdata = 8'h00;
    logic          we, re, rd_valid, full, empty, afull, aempty, ovf, unf;
    logic [AW-1:0] waddr, raddr;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk_i(clk), .n_rst_i(n_rst), .push_i(push), .pop_i(pop),
        .we_o(we), .re_o(re), .waddr_o(waddr), .raddr_o(raddr),
        .rd_valid_o(rd_valid), .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
        .overflow_o(ovf), .underflow_o(unf)
    );

    // Downstream RAM: read-before-write, one-cycle registered read.
    logic [7:0] ram [DEPTH];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        if (re) ram_q <= ram[raddr];
    end

    int total = 0;
    int bad = 0;

    int         mq[$];
    int         push_total, pop_total;
    logic       exp_ovf, exp_unf, exp_rdv;
    logic [7:0] exp_rdata;
    logic       exp_we, exp_re;
    int         exp_waddr, exp_raddr;
    logic       obs_we, obs_re;
    logic [AW-1:0] obs_waddr, obs_raddr;

    task automatic model_clear();
        mq.delete();
        push_total = 0;
        pop_total  = 0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
        exp_rdv    = 1'b0;
    endtask

    task automatic cycle(input logic p, input logic q);
        int sz;
        @(negedge clk);
        push  = p;
        pop   = q;
        wdata = 8'($urandom);
        #1;
        obs_we    = we;
        obs_re    = re;
        obs_waddr = waddr;
        obs_raddr = raddr;
        sz        = mq.size();
        exp_re    = q && (sz > 0);
        exp_we    = p && ((sz < DEPTH) || exp_re);
        exp_waddr = push_total % DEPTH;
        exp_raddr = pop_total % DEPTH;
        @(posedge clk);
        #1;
        if (p && sz == DEPTH && !exp_re) exp_ovf = 1'b1;
        if (q && sz == 0) exp_unf = 1'b1;
        exp_rdv = exp_re;
        if (exp_re) begin
            exp_rdata = 8'(mq.pop_front());
            pop_total++;
        end
        if (exp_we) begin
            mq.push_back(int'(wdata));
            push_total++;
        end
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic apply_reset(input logic p);
        @(negedge clk);
        n_rst = 1'b0;
        push  = p;
        pop   = 1'b0;
        wdata = 8'($urandom);
        #1;
        obs_we = we;
        @(posedge clk);
        #1;
        model_clear();
        n_rst = 1'b1;
        push  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL reset_count_flags: count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        total++; if (afull !== 1'b0 || aempty !== 1'b1) begin bad++; $display("[TB] FAIL reset_almost: af=%b ae=%b want 0/1", afull, aempty); end
        total++; if (ovf !== 1'b0 || unf !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_sticky: ovf=%b unf=%b rdv=%b want 0", ovf, unf, rd_valid); end
        total++; if (waddr !== 3'd0 || raddr !== 3'd0) begin bad++; $display("[TB] FAIL reset_ptrs: waddr=%0d raddr=%0d want 0", waddr, raddr); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0);
            total++; if (obs_we !== 1'b1 || obs_waddr !== AW'(i)) begin bad++; $display("[TB] FAIL fill_write[%0d]: we=%b waddr=%0d want 1/%0d", i, obs_we, obs_waddr, i); end
            total++; if (count !== CW'(i + 1)) begin bad++; $display("[TB] FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            total++; if (aempty !== (i + 1 <= AE) || afull !== (i + 1 >= AF)) begin bad++; $display("[TB] FAIL fill_almost[%0d]: ae=%b af=%b", i, aempty, afull); end
            total++; if (full !== (i + 1 == DEPTH) || empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_empty[%0d]: full=%b empty=%b", i, full, empty); end
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0);
        total++; if (obs_we !== 1'b0) begin bad++; $display("[TB] FAIL ovf_we: got %b want 0", obs_we); end
        total++; if (ovf !== 1'b1 || count !== 4'd8 || waddr !== 3'd0) begin bad++; $display("[TB] FAIL ovf_state: ovf=%b count=%0d waddr=%0d want 1/8/0", ovf, count, waddr); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1);
            total++; if (obs_re !== 1'b1 || obs_raddr !== AW'(i)) begin bad++; $display("[TB] FAIL drain_read[%0d]: re=%b raddr=%0d want 1/%0d", i, obs_re, obs_raddr, i); end
            total++; if (rd_valid !== 1'b1 || ram_q !== exp_rdata) begin bad++; $display("[TB] FAIL drain_data[%0d]: rdv=%b data=%h want 1/%h", i, rd_valid, ram_q, exp_rdata); end
        end
        total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("[TB] FAIL drain_empty: empty=%b count=%0d want 1/0", empty, count); end
        cycle(1'b0, 1'b1);
        total++; if (obs_re !== 1'b0 || unf !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL underflow: re=%b unf=%b rdv=%b want 0/1/0", obs_re, unf, rd_valid); end
    endtask

    task automatic test_wrap();
        int addrs[6] = '{5, 6, 7, 0, 1, 2};
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            total++; if (obs_waddr !== AW'(addrs[i])) begin bad++; $display("[TB] FAIL wrap_waddr[%0d]: got %0d want %0d", i, obs_waddr, addrs[i]); end
        end
        total++; if (count !== 4'd6 || afull !== 1'b1) begin bad++; $display("[TB] FAIL wrap_count: count=%0d af=%b want 6/1", count, afull); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            total++; if (obs_raddr !== AW'(addrs[i]) || ram_q !== exp_rdata) begin bad++; $display("[TB] FAIL wrap_pop[%0d]: raddr=%0d data=%h want %0d/%h", i, obs_raddr, ram_q, addrs[i], exp_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1);
            total++; if (obs_we !== 1'b1 || obs_re !== 1'b1 || obs_waddr !== obs_raddr) begin bad++; $display("[TB] FAIL b2b_ctrl[%0d]: we=%b re=%b wa=%0d ra=%0d", i, obs_we, obs_re, obs_waddr, obs_raddr); end
            total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("[TB] FAIL b2b_count[%0d]: count=%0d full=%b want 8/1", i, count, full); end
            total++; if (rd_valid !== 1'b1 || ram_q !== exp_rdata) begin bad++; $display("[TB] FAIL b2b_data[%0d]: rdv=%b data=%h want 1/%h", i, rd_valid, ram_q, exp_rdata); end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] keep;
        apply_reset(1'b0);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        keep = ram[5];
        apply_reset(1'b1);
        total++; if (obs_we !== 1'b0 || ram[5] !== keep) begin bad++; $display("[TB] FAIL midrst_write: we=%b ram5=%h want 0/%h", obs_we, ram[5], keep); end
        total++; if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_state: count=%0d empty=%b rdv=%b want 0/1/0", count, empty, rd_valid); end
        total++; if (waddr !== 3'd0 || raddr !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ptrs: wa=%0d ra=%0d ovf=%b unf=%b want 0", waddr, raddr, ovf, unf); end
    endtask

    task automatic test_random();
        int sz;
        int push_pct;
        apply_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            push_pct = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 99) < push_pct), ($urandom_range(0, 99) < 100 - push_pct));
            sz = mq.size();
            total++; if (obs_we !== exp_we || obs_re !== exp_re) begin bad++; $display("[TB] FAIL rnd_enables[%0d]: we=%b re=%b want %b/%b", i, obs_we, obs_re, exp_we, exp_re); end
            total++; if (obs_waddr !== AW'(exp_waddr) || obs_raddr !== AW'(exp_raddr)) begin bad++; $display("[TB] FAIL rnd_addr[%0d]: wa=%0d ra=%0d want %0d/%0d", i, obs_waddr, obs_raddr, exp_waddr, exp_raddr); end
            total++; if (count !== CW'(sz)) begin bad++; $display("[TB] FAIL rnd_count[%0d]: got %0d want %0d", i, count, sz); end
            total++; if (full !== (sz == DEPTH) || empty !== (sz == 0) || afull !== (sz >= AF) || aempty !== (sz <= AE)) begin bad++; $display("[TB] FAIL rnd_flags[%0d]: f=%b e=%b af=%b ae=%b size=%0d", i, full, empty, afull, aempty, sz); end
            total++; if (ovf !== exp_ovf || unf !== exp_unf || rd_valid !== exp_rdv) begin bad++; $display("[TB] FAIL rnd_sticky[%0d]: ovf=%b unf=%b rdv=%b want %b/%b/%b", i, ovf, unf, rd_valid, exp_ovf, exp_unf, exp_rdv); end
            if (exp_rdv) begin
                total++; if (ram_q !== exp_rdata) begin bad++; $display("[TB] FAIL rnd_data[%0d]: got %h want %h", i, ram_q, exp_rdata); end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Pointer and flag controller for the synchronous FIFO. It sits directly upstream of simple_dual_port_ram and drives its we_i/addr_a_i write side and re_i/addr_b_i read side. It accepts push/pop requests, blocks illegal ones, maintains occupancy and status flags, and issues rd_valid_o aligned with the RAM's 1-cycle registered read data.

Parameters:
DEPTH, 16, number of entries; any integer >= 2, power of two not required
ADDR_WIDTH, $clog2(DEPTH), RAM address width
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width
AF_THRESH, DEPTH-2, almost_full_o asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty_o asserts when count <= AE_THRESH

Ports:
clk_i  in  1  single clock, rising edge
n_rst_i  in  1  reset, synchronous, active-low
push_i  in  1  write request
pop_i  in  1  read request
we_o  out  1  RAM write enable (to we_i)
re_o  out  1  RAM read enable (to re_i)
waddr_o  out  ADDR_WIDTH  RAM write address (to addr_a_i)
raddr_o  out  ADDR_WIDTH  RAM read address (to addr_b_i)
rd_valid_o  out  1  RAM data_out_o is valid this cycle
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  CNT_WIDTH  current occupancy
overflow_o  out  1  sticky: push_i seen while full and not popped
underflow_o  out  1  sticky: pop_i seen while empty

Behaviour:
- Reset (n_rst_i low at a rising edge): wptr=0, rptr=0, count=0, rd_valid_o=0, full_o=0, empty_o=1, almost_full_o=(AF_THRESH==0), almost_empty_o=1, overflow_o=0, underflow_o=0. Reset is synchronous only and overrides any push/pop in the same cycle. RAM contents are not cleared.
- pop_ok = pop_i & ~empty_o.
- push_ok = push_i & (~full_o | pop_ok). A push while full is accepted only when paired with an accepted pop.
- we_o = push_ok and re_o = pop_ok, both combinational. waddr_o=wptr and raddr_o=rptr, both registered pointers driven directly.
- Pointer update: on push_ok, wptr <= (wptr==DEPTH-1) ? 0 : wptr+1. rptr follows the same rule on pop_ok. Explicit wrap; no power-of-two dependence.
- Count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- All flags are registered and derived from next-count, so they are valid in the same cycle count_o changes. There is no extra latency.
- rd_valid_o <= pop_ok. It is high exactly one cycle after re_o, matching the RAM's registered read.
- Push and pop while empty: pop is rejected, push is accepted, count becomes 1, and no rd_valid_o follows.
- Push and pop while full: both are accepted, with waddr_o==raddr_o. The RAM is read-before-write at the same edge, so the popped data is the old entry, which is correct. Count stays at DEPTH.
- overflow_o sets on push_i & full_o & ~pop_ok. underflow_o sets on pop_i & empty_o. Both hold until reset.
- Rejected requests change no pointer, count or RAM state.

Decomposition:
- Shared package fifo_pkg holds the ptr_next wrap function (pointer, DEPTH) and the localparam helpers for ADDR_WIDTH/CNT_WIDTH derivation.
- No sub-module inside this block. The natural next level is a fifo_sync top instantiating sync_fifo_ctrl plus simple_dual_port_ram, with RAM data_out_o paired with rd_valid_o.

Test Plan:
Use DEPTH=8, AF_THRESH=6, AE_THRESH=2 for all scenarios.
1. Reset, then 8 pushes with no pop: waddr_o steps 0..7, count_o 1..8, almost_empty_o drops at count 3, almost_full_o rises at count 6, full_o=1 at count 8, empty_o=0.
2. From full, push_i=1 with pop_i=0: we_o=0, wptr stays 0, overflow_o=1 next cycle, count_o stays 8.
3. From full, 8 pops: raddr_o 0..7, rd_valid_o high one cycle after each re_o, RAM data matches push order. After the 8th pop, empty_o=1 and count_o=0. A 9th pop gives re_o=0 and underflow_o=1.
4. Wrap: push 5, pop 5, then push 6. Writes land at addresses 5,6,7,0,1,2, count_o=6, almost_full_o=1. Pops return the same order.
5. Simultaneous push and pop at full (count 8) for 4 cycles: count_o stays 8, full_o stays 1, each pop returns the oldest value rather than the concurrently written one.
6. Drive n_rst_i low mid-stream at count 4 with push_i=1 asserted: next cycle count_o=0, pointers 0, empty_o=1, rd_valid_o=0, sticky flags cleared, and no write occurs.
